// File: rtl/sys1_input_ctrl.sv
// System 1 input front end: PS/2 and joystick merge, coin pulse shaping and
// DIP-switch capture driving the active-low INP/DSW buses of the game core.
module sys1_input_ctrl #(
  parameter int          PLAYERS   = 2,
  parameter int          DSW_BYTES = 8,
  parameter logic [15:0] COIN_LEN  = 16'd4800,
  parameter logic [15:0] COIN_GAP  = 16'd4800
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joy,
  input  logic                   cocktail,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [8*PLAYERS-1:0]   inp,
  output logic [7:0]             inp_sys,
  output logic [8*DSW_BYTES-1:0] dsw
);

  // Internal arrays always hold at least two players so the P2->P1 merge is well formed.
  localparam int NP = (PLAYERS < 2) ? 2 : PLAYERS;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PULSE = 2'd1, S_GAP = 2'd2} coin_st_e;

  // Per-player control order: 0 right, 1 left, 2 down, 3 up, 4 trig1, 5 trig2 (same as joy).
  logic       r_ps2_tog;
  logic [5:0] r_key_p1;
  logic [5:0] r_key_p2;
  logic       r_key_start1, r_key_start2, r_key_coin1, r_key_coin2, r_key_f1, r_key_f2;

  logic [16*NP-1:0] w_joy;
  logic [5:0]       w_ctrl [NP];
  logic [NP-1:0]    w_coin_req;
  logic             w_start1, w_start2, w_coin, w_ps2_evt, w_unused;

  coin_st_e           r_st  [PLAYERS];
  logic [15:0]        r_cnt [PLAYERS];
  logic [PLAYERS-1:0] r_req;
  logic [PLAYERS-1:0] r_req_d;

  logic [8*PLAYERS-1:0]   r_inp;
  logic [7:0]             r_inp_sys;
  logic [8*DSW_BYTES-1:0] r_dsw = '1;

  assign w_ps2_evt = ps2_key[10] ^ r_ps2_tog;
  assign w_unused  = ^w_joy;
  assign inp       = r_inp;
  assign inp_sys   = r_inp_sys;
  assign dsw       = r_dsw;

  // PS/2 event detection and key state registers.
  always_ff @(posedge clk_sys) begin
    r_ps2_tog <= ps2_key[10];
    if (reset) begin
      r_key_p1     <= 6'd0;
      r_key_p2     <= 6'd0;
      r_key_start1 <= 1'b0;
      r_key_start2 <= 1'b0;
      r_key_coin1  <= 1'b0;
      r_key_coin2  <= 1'b0;
      r_key_f1     <= 1'b0;
      r_key_f2     <= 1'b0;
    end else if (w_ps2_evt) begin
      // Arrow keys accept either E0 state; everything else needs the full 9-bit code.
      case (ps2_key[8:0])
        9'h075, 9'h175: r_key_p1[3]  <= ps2_key[9];
        9'h072, 9'h172: r_key_p1[2]  <= ps2_key[9];
        9'h06B, 9'h16B: r_key_p1[1]  <= ps2_key[9];
        9'h074, 9'h174: r_key_p1[0]  <= ps2_key[9];
        9'h029:         r_key_p1[4]  <= ps2_key[9];
        9'h014:         r_key_p1[5]  <= ps2_key[9];
        9'h005:         r_key_f1     <= ps2_key[9];
        9'h006:         r_key_f2     <= ps2_key[9];
        9'h016:         r_key_start1 <= ps2_key[9];
        9'h01E:         r_key_start2 <= ps2_key[9];
        9'h02E:         r_key_coin1  <= ps2_key[9];
        9'h036:         r_key_coin2  <= ps2_key[9];
        9'h02D:         r_key_p2[3]  <= ps2_key[9];
        9'h02B:         r_key_p2[2]  <= ps2_key[9];
        9'h023:         r_key_p2[1]  <= ps2_key[9];
        9'h034:         r_key_p2[0]  <= ps2_key[9];
        9'h01C:         r_key_p2[4]  <= ps2_key[9];
        9'h01B:         r_key_p2[5]  <= ps2_key[9];
        default:        ;
      endcase
    end
  end

  // Keyboard/joystick merge, start and coin request generation.
  always_comb begin
    w_joy = '0;
    w_joy[16*PLAYERS-1:0] = joy;
    w_start1 = r_key_start1 | r_key_f1;
    w_start2 = r_key_start2 | r_key_f2;
    w_coin   = 1'b0;
    for (int p = 0; p < NP; p++) begin
      w_ctrl[p]     = w_joy[16*p +: 6];
      w_coin_req[p] = w_joy[16*p+8];
      w_start1      = w_start1 | w_joy[16*p+6];
      w_start2      = w_start2 | w_joy[16*p+7];
    end
    w_ctrl[0]     = w_ctrl[0] | r_key_p1;
    w_ctrl[1]     = w_ctrl[1] | r_key_p2;
    w_coin_req[0] = w_coin_req[0] | r_key_coin1 | r_key_f1;
    w_coin_req[1] = w_coin_req[1] | r_key_coin2 | r_key_f2;
    w_ctrl[0]     = w_ctrl[0] | ((!cocktail && PLAYERS >= 2) ? w_ctrl[1] : 6'd0);
    for (int p = 0; p < PLAYERS; p++) begin
      w_coin = w_coin | (r_st[p] == S_PULSE);
    end
  end

  // Coin shapers: one fixed-width pulse per request rising edge, then a lockout gap.
  always_ff @(posedge clk_sys) begin
    for (int p = 0; p < PLAYERS; p++) begin
      if (reset) begin
        // Seeding both edge taps with the live request means a held coin cannot retrigger.
        r_st[p]    <= S_IDLE;
        r_cnt[p]   <= 16'd0;
        r_req[p]   <= w_coin_req[p];
        r_req_d[p] <= w_coin_req[p];
      end else begin
        r_req[p]   <= w_coin_req[p];
        r_req_d[p] <= r_req[p];
        case (r_st[p])
          S_IDLE: begin
            if (r_req[p] && !r_req_d[p]) begin
              r_st[p]  <= S_PULSE;
              r_cnt[p] <= COIN_LEN - 16'd1;
            end
          end
          S_PULSE: begin
            if (r_cnt[p] == 16'd0) begin
              r_st[p]  <= S_GAP;
              r_cnt[p] <= COIN_GAP - 16'd1;
            end else begin
              r_cnt[p] <= r_cnt[p] - 16'd1;
            end
          end
          S_GAP: begin
            if (r_cnt[p] == 16'd0) begin
              r_st[p] <= S_IDLE;
            end else begin
              r_cnt[p] <= r_cnt[p] - 16'd1;
            end
          end
          default: begin
            r_st[p]  <= S_IDLE;
            r_cnt[p] <= 16'd0;
          end
        endcase
      end
    end
  end

  // Active-low output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_inp     <= '1;
      r_inp_sys <= 8'hFF;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        r_inp[8*p +: 8] <= ~{w_ctrl[p][1], w_ctrl[p][0], w_ctrl[p][3], w_ctrl[p][2],
                             1'b0, w_ctrl[p][5], w_ctrl[p][4], 1'b0};
      end
      r_inp_sys <= ~{2'b00, w_start2, w_start1, 3'b000, w_coin};
    end
  end

  // DIP capture; deliberately ignores reset so settings survive a core reset.
  always_ff @(posedge clk_sys) begin
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'(DSW_BYTES)) begin
      for (int k = 0; k < DSW_BYTES; k++) begin
        if (ioctl_addr[2:0] == 3'(k)) begin
          r_dsw[8*k +: 8] <= ioctl_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// Directed self-checking bench for sys1_input_ctrl (2 players, 8 DIP bytes,
// COIN_LEN=4, COIN_GAP=3).
module tb_sys1_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joy;
  logic        cocktail;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] inp;
  logic [7:0]  inp_sys;
  logic [63:0] dsw;

  int          checks = 0;
  int          errors = 0;
  logic        tog;
  logic [19:0] vec;
  logic [9:0]  s1vec;

  sys1_input_ctrl #(
    .PLAYERS(2), .DSW_BYTES(8), .COIN_LEN(16'd4), .COIN_GAP(16'd3)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy(joy),
    .cocktail(cocktail), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .inp(inp), .inp_sys(inp_sys), .dsw(dsw)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2(input logic pressed, input logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; tog = 1'b1; ps2_key = {1'b1, 1'b1, 9'h175};
    joy = 32'h0; cocktail = 1'b0;
    ioctl_wr = 1'b0; ioctl_index = 8'd0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    step(3);
    check("rst_inp", inp, 16'hFFFF);
    check("rst_inp_sys", inp_sys, 8'hFF);
    check("pwrup_dsw", dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    reset = 1'b0;
    step(3);
    check("no_spurious_event", inp, 16'hFFFF);

    // PS/2 keys
    ps2(1'b1, 9'h175); step(1);
    check("p1_up_lat1", inp, 16'hFFFF);
    step(1);
    check("p1_up", inp, 16'hFFDF);
    ps2(1'b0, 9'h075); step(2);
    check("p1_up_rel_no_e0", inp, 16'hFFFF);
    ps2(1'b1, 9'h023); step(2);
    check("p2_left_merged", inp, 16'h7F7F);
    cocktail = 1'b1; step(1);
    check("p2_left_cocktail", inp, 16'h7FFF);
    ps2(1'b0, 9'h023); cocktail = 1'b0; step(2);
    check("p2_left_rel", inp, 16'hFFFF);
    ps2(1'b1, 9'h129); step(2);
    check("e0_exact_inp", inp, 16'hFFFF);
    check("e0_exact_sys", inp_sys, 8'hFF);
    ps2(1'b0, 9'h129); step(2);
    ps2(1'b1, 9'h01E); step(2);
    check("start2_key", inp_sys, 8'hDF);
    ps2(1'b0, 9'h01E); step(2);
    check("start2_rel", inp_sys, 8'hFF);

    // Joystick merge
    joy = 32'h0010_0000; step(1);
    check("joy_p2_trig1_merged", inp, 16'hFDFD);
    cocktail = 1'b1; step(1);
    check("joy_p2_trig1_cocktail", inp, 16'hFDFF);
    cocktail = 1'b0;
    joy = 32'h0080_0001; step(1);
    check("joy_right_start2", {inp_sys, inp}, 24'hDF_FFBF);
    joy = 32'h0; step(2);
    check("joy_released", {inp_sys, inp}, 24'hFF_FFFF);

    // Coin held for 20 cycles: one 4-cycle pulse starting 2 edges after the sampled rise
    for (int i = 0; i < 20; i++) begin
      joy = 32'h0000_0100; step(1); vec[i] = inp_sys[0];
    end
    check("coin_held", vec, 20'hFFFC3);
    joy = 32'h0; step(5);

    // Rise 2 cycles after the last low cycle is dropped; rise 4 cycles after is taken
    for (int i = 1; i <= 20; i++) begin
      joy = (i <= 3 || i == 8 || i >= 10) ? 32'h0000_0100 : 32'h0;
      step(1); vec[i-1] = inp_sys[0];
    end
    check("coin_gap_then_accept", vec, 20'hF87C3);
    joy = 32'h0; step(10);

    // Reset in the middle of a pulse, with a key and the coin request still held
    ps2(1'b1, 9'h029); step(2);
    check("p1_trig1_key", inp, 16'hFFFD);
    joy = 32'h0000_0100; step(3);
    check("coin_before_reset", inp_sys, 8'hFE);
    reset = 1'b1; step(1);
    check("reset_mid_pulse", inp_sys, 8'hFF);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1); vec[i] = inp_sys[0];
    end
    check("no_retrigger_after_reset", vec[7:0], 8'hFF);
    check("keys_cleared", inp, 16'hFFFF);
    ps2(1'b0, 9'h029);
    joy = 32'h0; step(2);
    for (int i = 0; i < 6; i++) begin
      joy = 32'h0000_0100; step(1); vec[i] = inp_sys[0];
    end
    check("coin_after_reset", vec[5:0], 6'h03);
    joy = 32'h0; step(10);

    // F1: start1 after 2 edges, coin pulse one edge later than a joystick coin
    for (int i = 0; i < 10; i++) begin
      if (i == 0) ps2(1'b1, 9'h005);
      step(1); vec[i] = inp_sys[0]; s1vec[i] = inp_sys[4];
    end
    check("f1_coin", vec[9:0], 10'h387);
    check("f1_start1", s1vec, 10'h001);
    ps2(1'b0, 9'h005); step(2);
    check("f1_rel", inp_sys, 8'hFF);
    step(5);

    // P1 and P2 coin together collapse into one window
    for (int i = 0; i < 12; i++) begin
      joy = 32'h0100_0100; step(1); vec[i] = inp_sys[0];
    end
    check("coin_p1_p2_merged", vec[11:0], 12'hFC3);
    joy = 32'h0; step(10);

    // DIP capture
    ioctl_index = 8'd254; ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h5A; step(1);
    check("dsw_addr0", dsw, 64'hFFFF_FFFF_FFFF_FF5A);
    ioctl_addr = 25'd9; ioctl_dout = 8'h11; step(1);
    check("dsw_addr9", dsw, 64'hFFFF_FFFF_FFFF_FF5A);
    ioctl_addr = 25'd8; ioctl_dout = 8'h77; step(1);
    check("dsw_addr8", dsw, 64'hFFFF_FFFF_FFFF_FF5A);
    ioctl_index = 8'd253; ioctl_addr = 25'd1; ioctl_dout = 8'h22; step(1);
    check("dsw_index253", dsw, 64'hFFFF_FFFF_FFFF_FF5A);
    ioctl_index = 8'd254; ioctl_addr = 25'd7; ioctl_dout = 8'h3C; step(1);
    check("dsw_addr7", dsw, 64'h3CFF_FFFF_FFFF_FF5A);
    ioctl_wr = 1'b0; ioctl_addr = 25'd2; ioctl_dout = 8'h99; step(1);
    check("dsw_no_wr", dsw, 64'h3CFF_FFFF_FFFF_FF5A);
    reset = 1'b1; step(2);
    reset = 1'b0; step(1);
    check("dsw_survives_reset", dsw, 64'h3CFF_FFFF_FFFF_FF5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys1_input_ctrl.md
# sys1_input_ctrl

Parametrised player-input and DIP-switch front end for the System 1 core. It decodes PS/2 key events, merges keyboard and per-player joystick words, and shapes coin requests into fixed-width pulses. It also captures DIP-switch bytes from the HPS download stream and drives the active-low INPx/DSWx buses into the game core. It replaces the ad-hoc keyboard/joystick/DSW logic in the top level and adds support for more players, a cocktail mode and coin debouncing.

## Interface
Parameters:
- PLAYERS, 2: number of player ports, 1..4.
- DSW_BYTES, 8: number of DIP bytes captured, 1..8.
- COIN_LEN, 16'd4800: coin pulse width in clk_sys cycles, ≥1.
- COIN_GAP, 16'd4800: minimum low time after a pulse before the next coin is accepted, ≥1.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scan code (bit 8 = E0 prefix).
- joy  in  16*PLAYERS  per-player joystick word, player n at [16n+15:16n]. Bits: 0 right, 1 left, 2 down, 3 up, 4 trig1, 5 trig2, 6 start1, 7 start2, 8 coin.
- cocktail  in  1  0: P2 controls also OR into P1; 1: players independent.
- ioctl_wr  in  1  download write strobe.
- ioctl_index  in  8  download index.
- ioctl_addr  in  25  download address.
- ioctl_dout  in  8  download data.
- inp  out  8*PLAYERS  active-low player ports. Per player: {left,right,up,down,0,trig2,trig1,0}, each bit inverted.
- inp_sys  out  8  active-low system port: ~{2'b00,start2,start1,3'b000,coin}.
- dsw  out  8*DSW_BYTES  DIP bytes, byte k at [8k+7:8k].

## Operation
- Key decode: a PS/2 event is accepted when ps2_key[10] differs from the registered previous value. On acceptance the matching key register takes ps2_key[9]. Unknown codes are ignored.
- Arrow codes match with the E0 prefix ignored: 75 up, 72 down, 6B left, 74 right → P1.
- All other codes need an exact 9-bit match:
  - P1 buttons: 029 trig1, 014 trig2.
  - F1 (005) = start1 + coin; F2 (006) = start2 + coin.
  - 016 start1, 01E start2, 02E coin P1, 036 coin P2.
  - P2 directions: 02D up, 02B down, 023 left, 034 right.
  - P2 buttons: 01C trig1, 01B trig2.
- Players 3 and 4 are joystick-only.
- Merge: each player's control = key OR own joystick bit.
  - If cocktail=0 and PLAYERS≥2, P1 directions/triggers also OR the merged P2 values.
  - start1/start2 = OR of keys and bit 6/7 of every joystick.
- Coin shaper, one per player. Request = that player's keyboard coin OR joy bit 8; F1/F2 feed P1/P2 respectively. States:
  - IDLE: a rising edge of the request → PULSE, counter loaded with COIN_LEN-1.
  - PULSE: coin output = 1; counter decrements; at 0 → GAP, counter loaded with COIN_GAP-1.
  - GAP: output 0; at 0 → IDLE.
  - Request edges in PULSE or GAP are dropped. Holding the request does not retrigger; it must fall and rise again.
- inp_sys coin = OR of all shaper outputs.
- DSW capture: when ioctl_wr && ioctl_index==254 && ioctl_addr < DSW_BYTES, dsw byte ioctl_addr[2:0] <= ioctl_dout. Other indices and addresses have no effect.
- Reset behaviour:
  - Clears all key registers and shaper states (to IDLE, counters 0).
  - Loads the previous-toggle register with the current ps2_key[10], so no spurious event is taken.
  - Does NOT clear dsw, so DIP settings survive a menu reset. dsw power-up value is all ones.

## Timing
- All outputs are registered.
- Reset outputs: inp = all 1s, inp_sys = 8'hFF, dsw unchanged.
- Joystick → inp/inp_sys start bits: 1 cycle.
- PS/2 event → inp: 2 cycles (key register, then output register).
- Coin: request rises at edge N (sampled) → output low at edge N+2, for exactly COIN_LEN cycles. Next accepted edge is no earlier than COIN_LEN+COIN_GAP cycles after pulse start.
- DSW write → dsw visible on the next cycle.
- Reset asserted mid-pulse: coin output deasserts on the next edge. A request still high after reset needs a new rising edge.

## Test plan
- Reset with ps2_key[10]=1, then release → inp = 16'hFFFF, inp_sys = 8'hFF, no key event taken.
- Toggle ps2_key with {1,9'h175} → P1 up: inp[5] = 0 two cycles later. Toggle with {0,9'h175} → back to 1.
- cocktail=0, joy P2 bit 4 = 1 → inp[1] = 0 and inp[9] = 0. With cocktail=1 → only inp[9] = 0.
- COIN_LEN=4, COIN_GAP=3: joy P1 bit 8 held 20 cycles → inp_sys[0] low exactly 4 cycles, once. A second rising edge 2 cycles after the pulse ends is ignored; one at 4 cycles after yields a second pulse.
- ioctl_index=254: write addr 0 = 8'h5A and addr 9 = 8'h11 (DSW_BYTES=8) → dsw[7:0] = 8'h5A, other bytes unchanged. Then pulse reset → dsw[7:0] still 8'h5A.
- F1 press → inp_sys[4] = 0 and one coin pulse. Coin on P1 and P2 simultaneously → single merged low window of COIN_LEN cycles.
